uart_tx_core: RTL and testbench

Serial UART transmitter serving the transmit side of the UART controller. It accepts one byte per handshake from the controller's `o_tx`/`o_tx_start` outputs and acknowledges acceptance with a one-cycle `tx_start_clear` pulse, which the controller uses to pop its TX FIFO. It then serialises an 8N1-style frame on `o_txd`, with optional parity and one or two stop bits. `o_tx_busy` feeds the controller's Tx_full/Tx_empty status bits.

---
 rtl/uart_tx_core.sv | 132 +++++++++++++
 tb/tb_uart_tx_core.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_core.sv
// UART transmit serialiser: accepts one byte per request/clear handshake and
// sends start, 8 data bits (LSB first), optional parity and 1 or 2 stop bits.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 104,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_tx,
  input  logic       i_tx_start,
  output logic       o_tx_start_clear,
  output logic       o_tx_busy,
  output logic       o_txd,
  output logic [2:0] o_dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_baud_cnt;
  logic [2:0]    r_bit_idx;
  logic          r_stop_idx;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_txd;
  logic          r_busy;
  logic          r_clear;
  logic          w_bit_end;

  assign w_bit_end = (r_state != S_IDLE) && (r_baud_cnt == LAST_CNT);

  // Handshake: i_tx_start is a level request, honoured only in IDLE; the edge
  // that honours it also raises o_tx_start_clear for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= 8'h00;
      r_parity   <= 1'b0;
      r_txd      <= 1'b1;
      r_busy     <= 1'b0;
      r_clear    <= 1'b0;
    end else begin
      r_clear <= 1'b0;
      if (r_state == S_IDLE || w_bit_end) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      // o_txd is loaded with the next bit on each transition edge, so the
      // line holds one registered value for the whole bit period.
      case (r_state)
        S_IDLE: begin
          if (i_tx_start) begin
            r_shift  <= i_tx;
            r_parity <= (^i_tx) ^ PARITY_ODD_BIT;
            r_state  <= S_START;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
            r_clear  <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_txd     <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit_idx == 3'd7) begin
              r_stop_idx <= 1'b0;
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_txd   <= r_parity;
              end else begin
                r_state <= S_STOP;
                r_txd   <= 1'b1;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_txd     <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_txd      <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            if (STOP_BITS == 2 && !r_stop_idx) begin
              r_stop_idx <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_txd            = r_txd;
  assign o_tx_busy        = r_busy;
  assign o_tx_start_clear = r_clear;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: an 8N1 instance checked through a frame scoreboard,
// plus even/odd parity instances with two stop bits checked by hand sequences.
module tb_uart_tx_core;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] tx;
  logic       tx_start;
  logic       clr0, busy0, txd0;
  logic [2:0] st0;
  logic [7:0] tx_p;
  logic       start_p;
  logic       clr_e, busy_e, txd_e;
  logic       clr_o, busy_o, txd_o;
  logic [2:0] st_e, st_o;

  uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_tx(tx), .i_tx_start(tx_start),
    .o_tx_start_clear(clr0), .o_tx_busy(busy0), .o_txd(txd0), .o_dbg_state(st0)
  );

  uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_even (
    .clk(clk), .rst_n(rst_n), .i_tx(tx_p), .i_tx_start(start_p),
    .o_tx_start_clear(clr_e), .o_tx_busy(busy_e), .o_txd(txd_e), .o_dbg_state(st_e)
  );

  uart_tx_core #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .i_tx(tx_p), .i_tx_start(start_p),
    .o_tx_start_clear(clr_o), .o_tx_busy(busy_o), .o_txd(txd_o), .o_dbg_state(st_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int clr_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (clr0) clr_cnt <= clr_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  int         start_cyc_q[$];
  int         checks = 0;
  int         errors = 0;
  logic       mon_en = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [9:0] frame_8n1(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  function automatic logic xor_bits(input logic [7:0] d);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) p = p ^ d[i];
    return p;
  endfunction

  // ---------------- monitor for the 8N1 instance ----------------
  logic       mon_prev;
  logic [9:0] mon_got;
  logic       mon_samp [0:39];
  int         mon_unstable, mon_busy_bad, mon_clr_bad;

  initial begin : monitor
    mon_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && mon_prev && txd0 == 1'b0) begin
        start_cyc_q.push_back(cyc);
        mon_got = '0;
        mon_unstable = 0;
        mon_busy_bad = 0;
        mon_clr_bad = 0;
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          mon_samp[k] = txd0;
          if (k % 4 == 2) mon_got[k/4] = txd0;
          if (busy0 !== 1'b1) mon_busy_bad++;
          if (clr0 !== (k == 0)) mon_clr_bad++;
        end
        for (int k = 0; k < 40; k++)
          if (mon_samp[k] !== mon_samp[k - (k % 4)]) mon_unstable++;
        check("bit_stable", mon_unstable, 0);
        check("busy_40_cycles", mon_busy_bad, 0);
        check("clear_one_cycle", mon_clr_bad, 0);
        @(negedge clk);
        check("idle_after_frame", {busy0, txd0}, 2'b01);
        mon_prev = txd0;
        check("sb_has_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("frame_bits", mon_got, exp_q.pop_front());
      end else begin
        mon_prev = txd0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic push);
    @(posedge clk); #1;
    tx = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back(frame_8n1(d));
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, n < 200, 1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  int         bad, n, c0, f0;
  logic [7:0] ctrl_q[$];
  logic [7:0] par_bytes [0:1];
  logic [11:0] got_e, got_o, exp_e, exp_o;
  int         busy_e_n, busy_o_n, clr_e_bad, clr_o_bad, unst_e, unst_o;

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h01, 10'b1000000010};
    vecs[5] = '{8'h80, 10'b1100000000};
    vecs[6] = '{8'h55, 10'b1010101010};
    par_bytes[0] = 8'hA5;
    par_bytes[1] = 8'h01;

    rst_n = 1'b0; tx = 8'h00; tx_start = 1'b0; tx_p = 8'h00; start_p = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", txd0, 1);
    check("reset_busy", busy0, 0);
    check("reset_clear", clr0, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ({txd0, busy0, clr0} !== 3'b100) bad++;
      if ({txd_e, busy_e, clr_e, txd_o, busy_o, clr_o} !== 6'b100100) bad++;
    end
    check("reset_idle_50", bad, 0);
    mon_en = 1'b1;

    // table-driven 8N1 frames
    for (int v = 0; v < 7; v++) begin
      @(posedge clk); #1;
      tx = vecs[v].data;
      tx_start = 1'b1;
      exp_q.push_back(vecs[v].frame);
      @(posedge clk); #1;
      tx_start = 1'b0;
      tx = 8'($urandom_range(0, 255));
      wait_idle("table");
    end

    // request while busy: second byte presented mid-frame
    send_byte(8'h55, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    c0 = clr_cnt;
    f0 = start_cyc_q.size();
    tx = 8'h00;
    tx_start = 1'b1;
    exp_q.push_back(frame_8n1(8'h00));
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!clr0 && n < 100);
    tx_start = 1'b0;
    tx = 8'($urandom_range(0, 255));
    check("busy_req_accept_timeout", n < 100, 1);
    check("busy_req_wait_cycles", n >= 30, 1);
    wait_idle("busy_req");
    check("busy_req_clear_count", clr_cnt - c0, 1);
    check("busy_req_frames", start_cyc_q.size() - f0, 1);
    if (start_cyc_q.size() >= 2)
      check("busy_req_gap", start_cyc_q[$] - start_cyc_q[$-1], 41);

    // back-to-back from a controller model
    ctrl_q = '{8'h01, 8'h80, 8'hFF};
    foreach (ctrl_q[i]) exp_q.push_back(frame_8n1(ctrl_q[i]));
    c0 = clr_cnt;
    f0 = start_cyc_q.size();
    @(posedge clk); #1;
    n = 0;
    while ((ctrl_q.size() > 0 || busy0) && n < 400) begin
      if (clr0) begin
        void'(ctrl_q.pop_front());
        tx_start = 1'b0;
      end else if (ctrl_q.size() > 0) begin
        tx = ctrl_q[0];
        tx_start = 1'b1;
      end else begin
        tx_start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    tx_start = 1'b0;
    check("b2b_timeout", n < 400, 1);
    wait_idle("b2b");
    check("b2b_clear_count", clr_cnt - c0, 3);
    check("b2b_frames", start_cyc_q.size() - f0, 3);
    if (start_cyc_q.size() - f0 == 3) begin
      check("b2b_gap_1", start_cyc_q[f0+1] - start_cyc_q[f0], 41);
      check("b2b_gap_2", start_cyc_q[f0+2] - start_cyc_q[f0+1], 41);
    end
    check("b2b_sb_empty", exp_q.size(), 0);

    // parity instances: even and odd, two stop bits, 48-cycle frames
    for (int v = 0; v < 2; v++) begin
      exp_e = {2'b11, xor_bits(par_bytes[v]),        par_bytes[v], 1'b0};
      exp_o = {2'b11, ~xor_bits(par_bytes[v]),       par_bytes[v], 1'b0};
      @(posedge clk); #1;
      tx_p = par_bytes[v];
      start_p = 1'b1;
      @(posedge clk); #1;
      start_p = 1'b0;
      tx_p = ~par_bytes[v];
      got_e = '0; got_o = '0;
      busy_e_n = 0; busy_o_n = 0; clr_e_bad = 0; clr_o_bad = 0; unst_e = 0; unst_o = 0;
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        if (k % 4 == 2) begin
          got_e[k/4] = txd_e;
          got_o[k/4] = txd_o;
        end
        if (k % 4 != 0 && txd_e !== got_e[k/4] && k % 4 > 2) unst_e++;
        if (k % 4 != 0 && txd_o !== got_o[k/4] && k % 4 > 2) unst_o++;
        if (busy_e) busy_e_n++;
        if (busy_o) busy_o_n++;
        if (clr_e !== (k == 0)) clr_e_bad++;
        if (clr_o !== (k == 0)) clr_o_bad++;
      end
      @(negedge clk);
      check("par_even_frame", got_e, exp_e);
      check("par_odd_frame", got_o, exp_o);
      check("par_even_busy_48", busy_e_n, 48);
      check("par_odd_busy_48", busy_o_n, 48);
      check("par_busy_drop", {busy_e, busy_o, txd_e, txd_o}, 4'b0011);
      check("par_clear_pulse", clr_e_bad + clr_o_bad, 0);
      check("par_bit_stable", unst_e + unst_o, 0);
      repeat (2) @(negedge clk);
    end

    // reset in the middle of data bit 3
    mon_en = 1'b0;
    send_byte(8'h00, 1'b0);
    repeat (17) @(negedge clk);
    check("txd_before_reset", {busy0, txd0}, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_txd", txd0, 1);
    check("midreset_busy", busy0, 0);
    check("midreset_clear", clr0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    mon_en = 1'b1;
    f0 = start_cyc_q.size();
    send_byte(8'h3C, 1'b1);
    wait_idle("post_reset");
    check("post_reset_frames", start_cyc_q.size() - f0, 1);
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule
